// File: rtl/nco_disp_pkg.sv
// -----------------------------------------------------------------------------
// nco_disp_pkg
// Shared definitions for the NCO-driven BCD counter and display scanner:
//   - bcd_t       : one BCD digit (4 bits)
//   - SEG_0..SEG_9: active-high 7-segment patterns, bit 6 = a ... bit 0 = g
//   - SEG_BLANK   : all segments off
//   - nco_inc()   : phase increment floor(cnt_hz * 2^nco_w / clk_hz)
//   - seg_decode(): BCD digit to segment pattern (A-F decode to blank)
// -----------------------------------------------------------------------------
package nco_disp_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Evaluated at elaboration only; 64-bit math keeps cnt_hz << nco_w exact
  // for accumulator widths up to 32 bits with any realistic tick rate.
  function automatic logic [63:0] nco_inc(input logic [63:0] clk_hz,
                                          input logic [63:0] cnt_hz,
                                          input int          nco_w);
    nco_inc = (cnt_hz << nco_w) / clk_hz;
  endfunction

  function automatic logic [6:0] seg_decode(input bcd_t d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/nco_tick_gen.sv
// -----------------------------------------------------------------------------
// nco_tick_gen
// Phase-accumulator NCO. Adds INC every cycle while run_i is high and emits a
// registered one-cycle tick on accumulator carry-out.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   run_i   1 = accumulate, 0 = hold phase (tick forced low)
//   clr_i   synchronous clear of the phase; wins over run_i, suppresses tick
//   tick_o  registered carry-out pulse
// -----------------------------------------------------------------------------
module nco_tick_gen #(
  parameter int               NCO_W = 32,
  parameter logic [NCO_W-1:0] INC   = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  logic [NCO_W-1:0] acc_q, acc_d;
  logic             tick_q, tick_d;
  logic [NCO_W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, INC};
    acc_d  = acc_q;
    tick_d = 1'b0;
    if (clr_i) begin
      acc_d = '0;
    end else if (run_i) begin
      acc_d  = sum[NCO_W-1:0];
      tick_d = sum[NCO_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/nco_cnt_disp_gen.sv
// -----------------------------------------------------------------------------
// nco_cnt_disp_gen
// NCO tick generator driving an N-digit cascaded BCD up/down counter, plus a
// multiplexed 7-segment scanner for the count.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   i_run      1 = NCO accumulates / counter advances, 0 = freeze
//   i_clr      synchronous clear of count and NCO phase (highest priority)
//   i_dir      0 = count up, 1 = count down (sampled at each step)
//   o_tick     registered NCO carry pulse
//   o_count    BCD count, digit 0 in [3:0]
//   o_seg_enb  one-hot active-high digit enable
//   o_seg_dp   active-high decimal point
//   o_seg      active-high segments, [6]=a ... [0]=g
// Build option:
//   LEADING_ZERO_BLANK_EN  blank display slots idx>0 whose digit and every
//                          higher digit are zero (digit 0 always shown)
// -----------------------------------------------------------------------------
module nco_cnt_disp_gen #(
  parameter int                    CLK_HZ     = 50000000,
  parameter int                    CNT_HZ     = 1,
  parameter int                    NCO_W      = 32,
  parameter int                    NUM_DIGITS = 6,
  parameter int                    SCAN_HZ    = 1000,
  parameter logic [NUM_DIGITS-1:0] DP_MASK    = 6'b010100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_run,
  input  logic                    i_clr,
  input  logic                    i_dir,
  output logic                    o_tick,
  output logic [4*NUM_DIGITS-1:0] o_count,
  output logic [NUM_DIGITS-1:0]   o_seg_enb,
  output logic                    o_seg_dp,
  output logic [6:0]              o_seg
);

  import nco_disp_pkg::*;

  localparam logic [63:0]      INC_FULL = nco_inc(64'(CLK_HZ), 64'(CNT_HZ), NCO_W);
  localparam logic [NCO_W-1:0] INC      = INC_FULL[NCO_W-1:0];
  localparam int               SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------- NCO
  logic tick;

  nco_tick_gen #(
    .NCO_W (NCO_W),
    .INC   (INC)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_i  (i_run),
    .clr_i  (i_clr),
    .tick_o (tick)
  );

  // ---------------------------------------------------------------- counter
  logic [4*NUM_DIGITS-1:0] count_q, count_d;
  logic [4*NUM_DIGITS-1:0] step_val;
  logic [NUM_DIGITS-1:0]   chain;   // carry (up) or borrow (down) into digit
  bcd_t                    dig [NUM_DIGITS];

  assign chain[0] = 1'b1;

  // Each digit moves only when every lower digit is wrapping (9->0 up,
  // 0->9 down), which gives all-9s <-> all-0s wrap for free.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign dig[gi] = count_q[4*gi +: 4];

    assign step_val[4*gi +: 4] =
        !chain[gi] ? dig[gi] :
        i_dir      ? ((dig[gi] == 4'd0) ? 4'd9 : dig[gi] - 4'd1) :
                     ((dig[gi] == 4'd9) ? 4'd0 : dig[gi] + 4'd1);

    if (gi < NUM_DIGITS - 1) begin : g_chain
      assign chain[gi+1] = chain[gi] &
                           (i_dir ? (dig[gi] == 4'd0) : (dig[gi] == 4'd9));
    end
  end

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------- scanner
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // ---------------------------------------------------------------- display
`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[d] = digit d and all digits above it are zero
  logic [NUM_DIGITS-1:0] upper_zero;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign upper_zero[gi] = (dig[gi] == 4'd0);
    end else begin : g_mid
      assign upper_zero[gi] = (dig[gi] == 4'd0) & upper_zero[gi+1];
    end
  end
`endif

  logic [NUM_DIGITS-1:0] enb_q, enb_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  always_comb begin
    enb_d        = '0;
    enb_d[idx_q] = 1'b1;
    seg_d        = seg_decode(dig[idx_q]);
    dp_d         = DP_MASK[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q != '0) && upper_zero[idx_q]) begin
      enb_d = '0;
      seg_d = SEG_BLANK;
      dp_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enb_q <= '0;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b0;
    end else begin
      enb_q <= enb_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign o_tick    = tick;
  assign o_count   = count_q;
  assign o_seg_enb = enb_q;
  assign o_seg     = seg_q;
  assign o_seg_dp  = dp_q;

endmodule

// File: tb/tb_nco_cnt_disp_gen.sv
// -----------------------------------------------------------------------------
// tb_nco_cnt_disp_gen
// Scoreboard bench: the stimulus process queues expected tick gaps, count
// values, scan-slot contents and reset snapshots; a monitor on the falling
// edge pops and compares them as the DUT produces each output.
// Config: CLK_HZ=1024, CNT_HZ=64, NCO_W=32, SCAN_HZ=256, NUM_DIGITS=6
//   -> INC = 2^28 (tick every 16 cycles), SCAN_DIV = 4.
// -----------------------------------------------------------------------------
module tb_nco_cnt_disp_gen;
  import nco_disp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_run = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_dir = 1'b0;
  logic        o_tick;
  logic [23:0] o_count;
  logic [5:0]  o_seg_enb;
  logic        o_seg_dp;
  logic [6:0]  o_seg;

  nco_cnt_disp_gen #(
    .CLK_HZ     (1024),
    .CNT_HZ     (64),
    .NCO_W      (32),
    .NUM_DIGITS (6),
    .SCAN_HZ    (256),
    .DP_MASK    (6'b010100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (i_run),
    .i_clr     (i_clr),
    .i_dir     (i_dir),
    .o_tick    (o_tick),
    .o_count   (o_count),
    .o_seg_enb (o_seg_enb),
    .o_seg_dp  (o_seg_dp),
    .o_seg     (o_seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] val;
    bit          need_tick;
  } cnt_item_t;

  typedef struct {
    int         idx;
    logic [5:0] enb;
    logic [6:0] seg;
    logic       dp;
  } scan_item_t;

  int         tick_q[$];
  cnt_item_t  cnt_q[$];
  scan_item_t scan_q[$];
  int         rst_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("check %s value=%0h ok", name, act);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int n);
    logic [23:0] r;
    int v;
    v = n;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic push_cnt(input int n, input bit need_tick);
    cnt_item_t ci;
    ci.val       = to_bcd(n);
    ci.need_tick = need_tick;
    cnt_q.push_back(ci);
  endtask

  task automatic push_scan(input int idx, input logic [5:0] enb, input logic [6:0] seg, input logic dp);
    scan_item_t si;
    si.idx = idx;
    si.enb = enb;
    si.seg = seg;
    si.dp  = dp;
    scan_q.push_back(si);
  endtask

  // ------------------------------------------------------------- monitor
  logic [23:0] prev_count = '0;
  bit          prev_tick  = 1'b0;
  int          gap        = 0;   // rising edges since last tick / clear / reset
  int          edge_k     = 0;   // rising edges since reset release

  always @(negedge clk) begin : monitor
    int         slot;
    int         pos;
    cnt_item_t  ci;
    scan_item_t si;
    if (!rst_n) begin
      if (rst_q.size() > 0) begin
        void'(rst_q.pop_front());
        chk("reset_outputs", 64'({o_tick, o_count, o_seg_enb, o_seg, o_seg_dp}), 64'd0);
      end
      prev_count = o_count;
      prev_tick  = 1'b0;
      gap        = 0;
      edge_k     = 0;
    end else begin
      edge_k++;
      gap++;
      if (o_tick) begin
        if (tick_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_tick actual=gap %0d required=no tick", gap);
        end else begin
          chk("tick_gap", 64'(gap), 64'(tick_q.pop_front()));
        end
        gap = 0;
      end
      if (i_clr) gap = 0;

      if (o_count !== prev_count) begin
        if (cnt_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_count actual=%h required=%h", o_count, prev_count);
        end else begin
          ci = cnt_q.pop_front();
          chk("count", 64'(o_count), 64'(ci.val));
          if (ci.need_tick) chk("count_after_tick", 64'(prev_tick), 64'd1);
        end
      end
      prev_count = o_count;
      prev_tick  = o_tick;

      if (scan_q.size() > 0) begin
        slot = ((edge_k - 1) / 4) % 6;
        pos  = (edge_k - 1) % 4;
        si   = scan_q[0];
        if (slot == si.idx && (pos == 0 || pos == 3)) begin
          chk($sformatf("scan_enb_idx%0d_p%0d", si.idx, pos), 64'(o_seg_enb), 64'(si.enb));
          chk($sformatf("scan_seg_idx%0d_p%0d", si.idx, pos), 64'(o_seg), 64'(si.seg));
          chk($sformatf("scan_dp_idx%0d_p%0d", si.idx, pos), 64'(o_seg_dp), 64'(si.dp));
          if (pos == 3) void'(scan_q.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_count(input logic [23:0] v, input int bound, input string name);
    int n;
    n = 0;
    while (o_count !== v && n < bound) begin
      step();
      n++;
    end
    if (o_count !== v) begin
      total++;
      bad++;
      $display("FAIL timeout_%s actual=%h required=%h", name, o_count, v);
    end
  endtask

  task automatic wait_tick(input int bound);
    int n;
    n = 0;
    while (o_tick !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    if (o_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout_tick actual=0 required=1");
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state, then count up from zero.
    i_run = 1'b1;
    i_dir = 1'b0;
    i_clr = 1'b0;
    rst_n = 1'b0;
    rst_q.push_back(1);
    repeat (3) step();
    for (int n = 1; n <= 42; n++) begin
      tick_q.push_back(16);
      push_cnt(n, 1'b1);
    end
    rst_n = 1'b1;
    wait_count(24'h000042, 1000, "c42");

    // Freeze mid-period for 100 cycles and scan the frozen 0x000042.
    i_run = 1'b0;
    push_scan(0, 6'b000001, SEG_2, 1'b0);
    push_scan(1, 6'b000010, SEG_4, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    push_scan(2, 6'b000000, SEG_BLANK, 1'b0);
    push_scan(3, 6'b000000, SEG_BLANK, 1'b0);
    push_scan(4, 6'b000000, SEG_BLANK, 1'b0);
    push_scan(5, 6'b000000, SEG_BLANK, 1'b0);
`else
    push_scan(2, 6'b000100, SEG_0, 1'b1);
    push_scan(3, 6'b001000, SEG_0, 1'b0);
    push_scan(4, 6'b010000, SEG_0, 1'b1);
    push_scan(5, 6'b100000, SEG_0, 1'b0);
`endif
    // One phase step was taken before the freeze, so 15 remain afterwards.
    tick_q.push_back(116);
    push_cnt(43, 1'b1);
    for (int n = 44; n <= 123; n++) begin
      tick_q.push_back(16);
      push_cnt(n, 1'b1);
    end
    tick_q.push_back(16);     // tick 124, swallowed by the clear below
    repeat (100) step();
    chk("scan_sweep_done", 64'(scan_q.size()), 64'd0);
    i_run = 1'b1;
    wait_count(24'h000123, 2000, "c123");

    // Clear coincident with a tick; select down for the next step.
    wait_tick(40);
    i_clr = 1'b1;
    i_dir = 1'b1;
    push_cnt(0, 1'b0);
    tick_q.push_back(16);
    push_cnt(999999, 1'b1);
    step();
    i_clr = 1'b0;
    wait_count(24'h999999, 100, "down_wrap");

    // Direction flips between ticks.
    i_dir = 1'b0;
    tick_q.push_back(16);
    push_cnt(0, 1'b1);
    wait_count(24'h000000, 100, "up_wrap");
    i_dir = 1'b1;
    tick_q.push_back(16);
    push_cnt(999999, 1'b1);
    wait_count(24'h999999, 100, "down_wrap2");

    // Asynchronous reset mid-period, asserted away from any edge.
    repeat (5) step();
    rst_q.push_back(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    step();
    step();
    i_dir = 1'b0;
    tick_q.push_back(16);
    push_cnt(1, 1'b1);
    rst_n = 1'b1;
    wait_count(24'h000001, 100, "after_reset");

    i_run = 1'b0;
    repeat (20) step();
    chk("tick_queue_drained", 64'(tick_q.size()), 64'd0);
    chk("count_queue_drained", 64'(cnt_q.size()), 64'd0);
    chk("scan_queue_drained", 64'(scan_q.size()), 64'd0);
    chk("reset_queue_drained", 64'(rst_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
